// File: rtl/fibo_ctrl_if.sv
// Control bundle between fibo_controller (master) and the datapath side (slave).
// The step input exists only when FIBO_CTRL_STEP_EN is defined.
interface fibo_ctrl_if;
   logic       start;
   logic       zero_flag;
   logic       wrt_en;
   logic       load_data;
   logic [1:0] wrt_addr;
   logic [1:0] rd_addr1;
   logic [1:0] rd_addr2;
   logic [2:0] alu_opcode;
   logic       busy;
   logic       done;
`ifdef FIBO_CTRL_STEP_EN
   logic       step;

   modport master (
      input  start, zero_flag, step,
      output wrt_en, load_data, wrt_addr, rd_addr1, rd_addr2, alu_opcode, busy, done
   );
   modport slave (
      output start, zero_flag, step,
      input  wrt_en, load_data, wrt_addr, rd_addr1, rd_addr2, alu_opcode, busy, done
   );
`else
   modport master (
      input  start, zero_flag,
      output wrt_en, load_data, wrt_addr, rd_addr1, rd_addr2, alu_opcode, busy, done
   );
   modport slave (
      output start, zero_flag,
      input  wrt_en, load_data, wrt_addr, rd_addr1, rd_addr2, alu_opcode, busy, done
   );
`endif
endinterface

// File: rtl/fibo_controller.sv
// Moore FSM sequencing FIBO_DATAPATH to compute F(n+2) into R1.
// Optional single-step mode is enabled by defining FIBO_CTRL_STEP_EN.
module fibo_controller #(
   parameter int size = 4
) (
   input  logic         clk,
   input  logic         rst,
   fibo_ctrl_if.master  bus
);

   typedef enum logic [3:0] {
      IDLE, LOAD, INIT1, INIT2, CHK, COPY, ADD, MOVE, DEC, DONE
   } state_t;

   if (size < 1) begin : g_sizeCheck
      $error("fibo_controller: size must be at least 1");
   end

   state_t     r_state;
   state_t     w_next;
   logic       w_advance;
   logic       r_wrt_en;
   logic       r_load_data;
   logic [1:0] r_wrt_addr;
   logic [1:0] r_rd_addr1;
   logic [1:0] r_rd_addr2;
   logic [2:0] r_alu_opcode;
   logic       r_busy;
   logic       r_done;

`ifdef FIBO_CTRL_STEP_EN
   assign w_advance  = bus.step;
   assign bus.wrt_en = r_wrt_en & bus.step;
`else
   assign w_advance  = 1'b1;
   assign bus.wrt_en = r_wrt_en;
`endif

   // IDLE and DONE react to start only; every busy state waits on w_advance.
   function automatic state_t nextState(input state_t s, input logic start,
                                        input logic zero, input logic adv);
      nextState = s;
      case (s)
         IDLE:    if (start) nextState = LOAD;
         LOAD:    if (adv)   nextState = INIT1;
         INIT1:   if (adv)   nextState = INIT2;
         INIT2:   if (adv)   nextState = CHK;
         CHK:     if (adv)   nextState = zero ? DONE : COPY;
         COPY:    if (adv)   nextState = ADD;
         ADD:     if (adv)   nextState = MOVE;
         MOVE:    if (adv)   nextState = DEC;
         DEC:     if (adv)   nextState = CHK;
         DONE:    if (!start) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   endfunction

   assign w_next = nextState(r_state, bus.start, bus.zero_flag, w_advance);

   // Outputs are decoded from the upcoming state so they register alongside it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_wrt_en     <= 1'b0;
         r_load_data  <= 1'b0;
         r_wrt_addr   <= 2'b00;
         r_rd_addr1   <= 2'b00;
         r_rd_addr2   <= 2'b00;
         r_alu_opcode <= 3'b000;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_wrt_en     <= 1'b0;
         r_load_data  <= 1'b0;
         r_wrt_addr   <= 2'b00;
         r_rd_addr1   <= 2'b00;
         r_rd_addr2   <= 2'b00;
         r_alu_opcode <= 3'b000;
         r_busy       <= (w_next != IDLE) && (w_next != DONE);
         r_done       <= (w_next == DONE);
         case (w_next)
            LOAD: begin
               r_wrt_en     <= 1'b1;
               r_load_data  <= 1'b1;
               r_alu_opcode <= 3'b100;
            end
            INIT1: begin
               r_wrt_en     <= 1'b1;
               r_wrt_addr   <= 2'b01;
               r_rd_addr1   <= 2'b01;
               r_rd_addr2   <= 2'b01;
               r_alu_opcode <= 3'b001;
            end
            INIT2: begin
               r_wrt_en     <= 1'b1;
               r_wrt_addr   <= 2'b10;
               r_rd_addr1   <= 2'b10;
               r_rd_addr2   <= 2'b10;
               r_alu_opcode <= 3'b001;
            end
            CHK: begin
               r_alu_opcode <= 3'b111;
            end
            COPY: begin
               r_wrt_en     <= 1'b1;
               r_wrt_addr   <= 2'b11;
               r_rd_addr1   <= 2'b01;
               r_rd_addr2   <= 2'b01;
               r_alu_opcode <= 3'b111;
            end
            ADD: begin
               r_wrt_en     <= 1'b1;
               r_wrt_addr   <= 2'b01;
               r_rd_addr1   <= 2'b01;
               r_rd_addr2   <= 2'b10;
               r_alu_opcode <= 3'b110;
            end
            MOVE: begin
               r_wrt_en     <= 1'b1;
               r_wrt_addr   <= 2'b10;
               r_rd_addr1   <= 2'b11;
               r_rd_addr2   <= 2'b11;
               r_alu_opcode <= 3'b111;
            end
            DEC: begin
               r_wrt_en     <= 1'b1;
               r_alu_opcode <= 3'b010;
            end
            DONE: begin
               r_rd_addr1   <= 2'b01;
               r_rd_addr2   <= 2'b01;
               r_alu_opcode <= 3'b111;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.load_data  = r_load_data;
   assign bus.wrt_addr   = r_wrt_addr;
   assign bus.rd_addr1   = r_rd_addr1;
   assign bus.rd_addr2   = r_rd_addr2;
   assign bus.alu_opcode = r_alu_opcode;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;

endmodule

// File: tb/tb_fibo_controller.sv
// Bench for fibo_controller with a small behavioural datapath model.
// Checks per-cycle outputs against a per-state table for several counts.
module tb_fibo_controller;

   localparam int SIZE = 4;

   localparam int S_IDLE = 0, S_LOAD = 1, S_INIT1 = 2, S_INIT2 = 3, S_CHK = 4,
                  S_COPY = 5, S_ADD = 6, S_MOVE = 7, S_DEC = 8, S_DONE = 9;

   typedef struct {
      int            n;
      logic [SIZE-1:0] expData;
      int            expLatency;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [SIZE-1:0] count = '0;
   logic [SIZE-1:0] rf [4];
   logic [SIZE-1:0] result;
   int              total = 0;
   int              bad = 0;
   int              writeCount = 0;

   fibo_ctrl_if bus ();

   fibo_controller #(.size(SIZE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Behavioural FIBO_DATAPATH: read port shows the ALU result.
   always_comb begin
      result = '0;
      case (bus.alu_opcode)
         3'b100:  result = count;
         3'b001:  result = 1;
         3'b111:  result = rf[bus.rd_addr1];
         3'b110:  result = rf[bus.rd_addr1] + rf[bus.rd_addr2];
         3'b010:  result = rf[bus.rd_addr1] - 1'b1;
         default: result = '0;
      endcase
   end

   assign bus.zero_flag = (result == '0);

   always @(posedge clk) begin
      if (bus.wrt_en) begin
         rf[bus.wrt_addr] <= bus.load_data ? count : result;
         writeCount <= writeCount + 1;
      end
   end

   function automatic logic [12:0] stateOut(input int s);
      // {wrt_en, load_data, wrt_addr, rd_addr1, rd_addr2, alu_opcode, busy, done}
      case (s)
         S_LOAD:  stateOut = {1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 3'b100, 1'b1, 1'b0};
         S_INIT1: stateOut = {1'b1, 1'b0, 2'b01, 2'b01, 2'b01, 3'b001, 1'b1, 1'b0};
         S_INIT2: stateOut = {1'b1, 1'b0, 2'b10, 2'b10, 2'b10, 3'b001, 1'b1, 1'b0};
         S_CHK:   stateOut = {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b111, 1'b1, 1'b0};
         S_COPY:  stateOut = {1'b1, 1'b0, 2'b11, 2'b01, 2'b01, 3'b111, 1'b1, 1'b0};
         S_ADD:   stateOut = {1'b1, 1'b0, 2'b01, 2'b01, 2'b10, 3'b110, 1'b1, 1'b0};
         S_MOVE:  stateOut = {1'b1, 1'b0, 2'b10, 2'b11, 2'b11, 3'b111, 1'b1, 1'b0};
         S_DEC:   stateOut = {1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 1'b1, 1'b0};
         S_DONE:  stateOut = {1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b111, 1'b0, 1'b1};
         default: stateOut = 13'd0;
      endcase
   endfunction

   // State expected k edges after the start edge for count n.
   function automatic int expState(input int k, input int n);
      int j;
      if (k == 0) return S_LOAD;
      if (k == 1) return S_INIT1;
      if (k == 2) return S_INIT2;
      j = k - 3;
      if (j == 5 * n) return S_CHK;
      if (j > 5 * n) return S_DONE;
      case (j % 5)
         0:       return S_CHK;
         1:       return S_COPY;
         2:       return S_ADD;
         3:       return S_MOVE;
         default: return S_DEC;
      endcase
   endfunction

   function automatic logic [12:0] dutOut();
      return {bus.wrt_en, bus.load_data, bus.wrt_addr, bus.rd_addr1, bus.rd_addr2,
              bus.alu_opcode, bus.busy, bus.done};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // One full computation with start pulsed for a single cycle.
   task automatic applyStimulus(input vec_t v);
      int doneAt;
      int busyCycles;
      doneAt = -1;
      busyCycles = 0;
      count = v.n[SIZE-1:0];
      @(negedge clk) bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int k = 0; k <= 4 + 5 * v.n; k++) begin
         if (k != 0) begin
            @(posedge clk);
            #1;
         end
         checkOutput($sformatf("n%0d_cycle%0d", v.n, k), 32'(dutOut()),
                     32'(stateOut(expState(k, v.n))));
         if (bus.busy) busyCycles++;
         if (bus.done && doneAt < 0) doneAt = k;
      end
      checkOutput($sformatf("n%0d_doneLatency", v.n), 32'(doneAt), 32'(v.expLatency));
      checkOutput($sformatf("n%0d_busyCycles", v.n), 32'(busyCycles), 32'(v.expLatency));
      checkOutput($sformatf("n%0d_data", v.n), 32'(result), 32'(v.expData));
      @(posedge clk);
      #1 checkOutput($sformatf("n%0d_backToIdle", v.n), 32'(dutOut()), 32'(stateOut(S_IDLE)));
   endtask

   initial begin
      vec_t vecs [6];
      vec_t v;
      int   writesBefore;
      bit   sawDone;

      vecs[0] = '{n: 4,  expData: 4'd8,  expLatency: 24};
      vecs[1] = '{n: 0,  expData: 4'd1,  expLatency: 4};
      vecs[2] = '{n: 1,  expData: 4'd2,  expLatency: 9};
      vecs[3] = '{n: 2,  expData: 4'd3,  expLatency: 14};
      vecs[4] = '{n: 6,  expData: 4'd5,  expLatency: 34};
      vecs[5] = '{n: 15, expData: 4'd13, expLatency: 79};

      bus.start = 1'b0;
`ifdef FIBO_CTRL_STEP_EN
      bus.step = 1'b1;
`endif
      #1 checkOutput("resetOutputs", 32'(dutOut()), 32'd0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1 checkOutput("idleAfterReset", 32'(dutOut()), 32'(stateOut(S_IDLE)));

      for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

      // Asynchronous reset while in ADD of the first iteration.
      count = 4'd4;
      @(negedge clk) bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int k = 1; k <= 5; k++) @(posedge clk);
      #1 checkOutput("midLoopInAdd", 32'(dutOut()), 32'(stateOut(S_ADD)));
      rst = 1'b1;
      #1 checkOutput("asyncResetOutputs", 32'(dutOut()), 32'd0);
      @(negedge clk) rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1 checkOutput($sformatf("idleHold%0d", k), 32'(dutOut()), 32'(stateOut(S_IDLE)));
      end

      // start held high through completion, then dropped and re-asserted.
      count = 4'd1;
      @(negedge clk) bus.start = 1'b1;
      for (int k = 0; k <= 9; k++) begin
         @(posedge clk);
         #1 checkOutput($sformatf("held_cycle%0d", k), 32'(dutOut()),
                        32'(stateOut(expState(k, 1))));
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1 checkOutput($sformatf("heldDone%0d", k), 32'(dutOut()), 32'(stateOut(S_DONE)));
      end
      checkOutput("heldData", 32'(result), 32'd2);
      @(negedge clk) bus.start = 1'b0;
      @(posedge clk);
      #1 checkOutput("dropToIdle", 32'(dutOut()), 32'(stateOut(S_IDLE)));
      @(negedge clk) bus.start = 1'b1;
      @(posedge clk);
      #1 checkOutput("restartLoad", 32'(dutOut()), 32'(stateOut(S_LOAD)));
      bus.start = 1'b0;
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;

`ifdef FIBO_CTRL_STEP_EN
      // Single-step run: one write per step pulse in write states.
      bus.step = 1'b0;
      count = 4'd1;
      @(negedge clk) bus.start = 1'b1;
      writesBefore = writeCount;
      @(posedge clk);
      #1 bus.start = 1'b0;
      sawDone = 1'b0;
      for (int c = 0; c < 100 && !sawDone; c++) begin
         @(negedge clk) bus.step = (c % 3 == 2);
         @(posedge clk);
         #1 sawDone = bus.done;
      end
      checkOutput("stepDoneReached", 32'(sawDone), 32'd1);
      checkOutput("stepWrites", 32'(writeCount - writesBefore), 32'd7);
      checkOutput("stepData", 32'(result), 32'd2);
      bus.step = 1'b1;
`else
      writesBefore = writeCount;
      sawDone = 1'b0;
      v = vecs[0];
      checkOutput("noWritesWhileReset", 32'(writeCount - writesBefore), 32'd0);
      if (sawDone) checkOutput("unexpectedDone", 32'(v.n), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
